// File: rtl/mic_cap_pkg.sv
// Shared types and width helpers for the I2S microphone-array capture block.
// Imported by i2s_clk_gen and mic_array_capture.
package mic_cap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int bit_w(input int slot_bits);
        return $clog2(2 * slot_bits);
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Free-running I2S bit clock / word select generator with bit index and
// single-cycle strobes aligned to the clk edge on which SCK changes.
module i2s_clk_gen
    import mic_cap_pkg::*;
#(
    parameter int CLK_DIV   = 20,
    parameter int SLOT_BITS = 32,
    parameter int SAMPLE_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         o_sck,
    output logic                         o_ws,
    output logic [bit_w(SLOT_BITS)-1:0]  o_bit,
    output logic                         o_sck_rise,
    output logic                         o_ws_fall,
    output logic                         o_sample_strobe
);

    localparam int BIT_W = bit_w(SLOT_BITS);
    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] r_div;
    logic             r_sck;
    logic             r_ws;
    logic [BIT_W-1:0] r_bit;

    logic             w_tick;
    logic             w_fall;
    logic [BIT_W-1:0] w_bit_nxt;
    logic             w_ws_nxt;

    assign w_tick    = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_fall    = w_tick && r_sck;
    assign w_bit_nxt = (r_bit == BIT_W'(2 * SLOT_BITS - 1)) ? '0 : r_bit + 1'b1;
    assign w_ws_nxt  = (w_bit_nxt >= BIT_W'(SLOT_BITS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
            r_sck <= 1'b0;
            r_ws  <= 1'b1;
            r_bit <= '0;
        end else begin
            if (w_tick) begin
                r_div <= '0;
                r_sck <= ~r_sck;
            end else begin
                r_div <= r_div + 1'b1;
            end
            if (w_fall) begin
                r_bit <= w_bit_nxt;
                r_ws  <= w_ws_nxt;
            end
        end
    end

    assign o_sck      = r_sck;
    assign o_ws       = r_ws;
    assign o_bit      = r_bit;
    assign o_sck_rise = w_tick && !r_sck;
    // Only a true slot boundary counts; the WS drop right after reset is short.
    assign o_ws_fall  = w_fall && (w_bit_nxt == '0);
    assign o_sample_strobe = o_sck_rise && (r_bit == BIT_W'(SAMPLE_W));

endmodule

// File: rtl/mic_array_capture.sv
// N-channel I2S MEMS-mic capture: shared SCK/WS, per-channel deserialisers, frame buffer.
// Define MIC_CAP_TEST_PATTERN_EN to store (index + 16*channel) instead of mic data.
module mic_array_capture
    import mic_cap_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int SAMPLE_W  = 16,
    parameter int SLOT_BITS = 32,
    parameter int FRAME_LEN = 512,
    parameter int CLK_DIV   = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          xc_en,
    input  logic [NUM_CH-1:0]             mic_da,
    output logic                          mic_sck,
    output logic                          mic_ws,
    output logic                          mic_lr,
    output logic                          frame_valid,
    input  logic                          frame_ack,
    input  logic [ch_w(NUM_CH)-1:0]       rd_ch,
    input  logic [addr_w(FRAME_LEN)-1:0]  rd_addr,
    output logic signed [SAMPLE_W-1:0]    rd_data,
    output logic                          busy,
    output logic                          overrun
);

    localparam int ADDR_W = addr_w(FRAME_LEN);
    localparam int BIT_W  = bit_w(SLOT_BITS);

    logic             w_sck;
    logic             w_ws;
    logic             w_sck_rise;
    logic             w_ws_fall;
    logic             w_strobe;
    logic             w_shift;
    logic [BIT_W-1:0] w_bit;

    i2s_clk_gen #(
        .CLK_DIV   (CLK_DIV),
        .SLOT_BITS (SLOT_BITS),
        .SAMPLE_W  (SAMPLE_W)
    ) u_clk_gen (
        .clk             (clk),
        .rst             (rst),
        .o_sck           (w_sck),
        .o_ws            (w_ws),
        .o_bit           (w_bit),
        .o_sck_rise      (w_sck_rise),
        .o_ws_fall       (w_ws_fall),
        .o_sample_strobe (w_strobe)
    );

    // I2S one-bit delay: sample MSB sits on bit 1 of the left slot.
    assign w_shift = w_sck_rise
                  && (w_bit >= BIT_W'(1))
                  && (w_bit <= BIT_W'(SAMPLE_W));

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_wr_idx;
    logic                r_overrun;
    logic                w_we;
    logic                w_last;
    logic [SAMPLE_W-1:0] r_rd_data;

    logic [SAMPLE_W-1:0] r_sr     [NUM_CH];
    logic [SAMPLE_W-1:0] w_sr_nxt [NUM_CH];
    logic [SAMPLE_W-1:0] w_wdata  [NUM_CH];
    logic [SAMPLE_W-1:0] r_mem    [NUM_CH][FRAME_LEN];

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_sr_nxt[c] = {r_sr[c][SAMPLE_W-2:0], mic_da[c]};
`ifdef MIC_CAP_TEST_PATTERN_EN
            w_wdata[c] = SAMPLE_W'(int'(r_wr_idx) + 16 * c);
`else
            w_wdata[c] = w_sr_nxt[c];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_sr[c] <= '0;
            end
        end else if (w_shift) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_sr[c] <= w_sr_nxt[c];
            end
        end
    end

    assign w_last = (r_wr_idx == ADDR_W'(FRAME_LEN - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (xc_en) w_state_nxt = SYNC;
            end
            SYNC: begin
                if (!xc_en)         w_state_nxt = IDLE;
                else if (w_ws_fall) w_state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (!xc_en) begin
                    w_state_nxt = IDLE;
                end else if (w_strobe) begin
                    w_we = 1'b1;
                    if (w_last) w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (frame_ack) w_state_nxt = xc_en ? SYNC : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_wr_idx  <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_we) begin
                r_wr_idx <= w_last ? '0 : r_wr_idx + 1'b1;
            end else if (r_state != CAPTURE || !xc_en) begin
                r_wr_idx <= '0;
            end
            // A pending ack releases the frame, so that strobe is not a loss.
            if (r_state == DONE && w_strobe && !frame_ack) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_mem[c][r_wr_idx] <= w_wdata[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (int'(rd_ch) < NUM_CH) begin
            r_rd_data <= r_mem[rd_ch][rd_addr];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign mic_sck     = w_sck;
    assign mic_ws      = w_ws;
    assign mic_lr      = 1'b0;
    assign frame_valid = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign overrun     = r_overrun;
    assign rd_data     = r_rd_data;

endmodule

// File: tb/tb_mic_array_capture.sv
// Scoreboard bench for mic_array_capture with an I2S left-slot mic model.
// Reduced timing parameters keep whole frames short.
module tb_mic_array_capture;

    localparam int NUM_CH    = 3;
    localparam int SAMPLE_W  = 16;
    localparam int SLOT_BITS = 18;
    localparam int FRAME_LEN = 8;
    localparam int CLK_DIV   = 2;
    localparam int WS_PER    = 4 * SLOT_BITS * CLK_DIV;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     xc_en = 1'b0;
    logic                     frame_ack = 1'b0;
    logic [NUM_CH-1:0]        mic_da;
    logic                     mic_sck, mic_ws, mic_lr;
    logic                     frame_valid, busy, overrun;
    logic [1:0]               rd_ch = '0;
    logic [2:0]               rd_addr = '0;
    logic signed [SAMPLE_W-1:0] rd_data;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] smp [NUM_CH];
    logic [15:0] cap [NUM_CH];

    always #5 clk = ~clk;

    mic_array_capture #(
        .NUM_CH    (NUM_CH),
        .SAMPLE_W  (SAMPLE_W),
        .SLOT_BITS (SLOT_BITS),
        .FRAME_LEN (FRAME_LEN),
        .CLK_DIV   (CLK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .xc_en       (xc_en),
        .mic_da      (mic_da),
        .mic_sck     (mic_sck),
        .mic_ws      (mic_ws),
        .mic_lr      (mic_lr),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .rd_ch       (rd_ch),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .overrun     (overrun)
    );

    // I2S mic: new bit after each SCK fall, MSB one bit after WS drops.
    initial begin
        int  cnt;
        logic psck, pws;
        cnt = 0; psck = 1'b0; pws = 1'b1;
        mic_da = '0;
        forever begin
            @(negedge clk);
            if (psck === 1'b1 && mic_sck === 1'b0) begin
                if (pws === 1'b1 && mic_ws === 1'b0) cnt = 0;
                else cnt++;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (mic_ws === 1'b0 && cnt >= 1 && cnt <= SAMPLE_W)
                        mic_da[c] = smp[c][SAMPLE_W - cnt];
                    else
                        mic_da[c] = 1'($urandom_range(0, 1));
                end
            end
            psck = mic_sck;
            pws  = mic_ws;
        end
    end

    typedef struct {
        string       nm;
        logic [15:0] exp;
    } sb_t;

    sb_t  sbq[$];
    logic rd_req = 1'b0;
    logic rd_req_d = 1'b0;

    always @(posedge clk) rd_req_d <= rd_req;

    always @(negedge clk) begin
        sb_t e;
        if (rd_req_d) begin
            n_chk++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL sb_empty: rd_data=%0d with no expected entry", rd_data);
            end else begin
                e = sbq.pop_front();
                if (rd_data !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: rd_data=%0d expected %0d",
                             e.nm, rd_data, $signed(e.exp));
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] expv(input int c, input int i);
`ifdef MIC_CAP_TEST_PATTERN_EN
        return 16'(i + 16 * c);
`else
        return (i >= 0) ? cap[c] : 16'h0;
`endif
    endfunction

    task automatic rd(input int ch, input int addr, input logic [15:0] e, input string nm);
        rd_ch   = 2'(ch);
        rd_addr = 3'(addr);
        rd_req  = 1'b1;
        sbq.push_back('{nm, e});
        @(negedge clk);
    endtask

    task automatic read_frame(input string nm);
        for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < FRAME_LEN; i++)
                rd(c, i, expv(c, i), $sformatf("%s_ch%0d_%0d", nm, c, i));
        rd(3, 5, 16'h0, {nm, "_ch_oob"});
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_fv(input logic lvl, input int budget, input string nm);
        int n;
        n = 0;
        while (frame_valid !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(frame_valid), 32'(lvl));
    endtask

    int idle_bad = 0;

    task automatic wait_ws_fall(output int n);
        logic p, fell;
        n = 0;
        p = mic_ws;
        fell = 1'b0;
        while (!fell && n < 1000) begin
            @(negedge clk);
            n++;
            if (busy !== 1'b0 || frame_valid !== 1'b0) idle_bad++;
            fell = (p === 1'b1 && mic_ws === 1'b0);
            p = mic_ws;
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_sck"}, 32'(mic_sck), 32'd0);
        chk({nm, "_ws"}, 32'(mic_ws), 32'd1);
        chk({nm, "_lr"}, 32'(mic_lr), 32'd0);
        chk({nm, "_fv"}, 32'(frame_valid), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_ovr"}, 32'(overrun), 32'd0);
        chk({nm, "_rd"}, 32'(rd_data), 32'd0);
    endtask

    initial begin
        int n;
        logic p;

        smp[0] = 16'h8001; smp[1] = 16'h7FFE; smp[2] = 16'hA5C3;
        cap = smp;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            n = 0;
            p = mic_sck;
            while (mic_sck === p && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("sck_half%0d", k), 32'(n), 32'(CLK_DIV));
        end

        wait_ws_fall(n);
        wait_ws_fall(n);
        wait_ws_fall(n);
        chk("ws_period", 32'(n), 32'(WS_PER));
        repeat (300) begin
            @(negedge clk);
            if (busy !== 1'b0 || frame_valid !== 1'b0) idle_bad++;
        end
        chk("idle_no_busy_fv", 32'(idle_bad), 32'd0);

        xc_en = 1'b1;
        @(negedge clk);
        chk("busy_sync", 32'(busy), 32'd1);
        wait_fv(1'b1, 12 * WS_PER, "frame1_valid");
        chk("frame1_no_ovr", 32'(overrun), 32'd0);
        read_frame("f1");

        smp[0] = 16'h1111; smp[1] = 16'hEEEE; smp[2] = 16'h3C3C;
        repeat (WS_PER + 10) @(negedge clk);
        chk("overrun_set", 32'(overrun), 32'd1);
        chk("done_hold_fv", 32'(frame_valid), 32'd1);
        read_frame("frozen");

        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        chk("ack_fv_clear", 32'(frame_valid), 32'd0);
        chk("ack_to_sync", 32'(busy), 32'd1);
        cap = smp;
        wait_fv(1'b1, 12 * WS_PER, "frame2_valid");
        chk("overrun_sticky", 32'(overrun), 32'd1);
        read_frame("f2");

        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        repeat (4 * WS_PER + WS_PER / 2) @(negedge clk);
        chk("mid_capture_busy", 32'(busy), 32'd1);
        chk("mid_capture_fv", 32'(frame_valid), 32'd0);
        xc_en = 1'b0;
        @(negedge clk);
        chk("abort_idle", 32'(busy), 32'd0);
        smp[0] = 16'h0F0F; smp[1] = 16'hFFFF; smp[2] = 16'h0001;
        cap = smp;
        n = 0;
        repeat (10 * WS_PER) begin
            @(negedge clk);
            if (frame_valid !== 1'b0) n++;
        end
        chk("abort_no_fv", 32'(n), 32'd0);
        xc_en = 1'b1;
        wait_fv(1'b1, 12 * WS_PER, "frame3_valid");
        read_frame("f3");

        xc_en = 1'b0;
        repeat (50) @(negedge clk);
        chk("done_no_en_fv", 32'(frame_valid), 32'd1);
        chk("done_no_en_busy", 32'(busy), 32'd1);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        chk("ack_idle_fv", 32'(frame_valid), 32'd0);
        chk("ack_idle_busy", 32'(busy), 32'd0);

        xc_en = 1'b1;
        rd_ch = 2'd0;
        rd_addr = 3'd1;
        repeat (3 * WS_PER) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_rd_nonzero", 32'(rd_data != 0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst = 1'b0;
        xc_en = 1'b0;
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        chk("idle_ack_busy", 32'(busy), 32'd0);
        chk("idle_ack_fv", 32'(frame_valid), 32'd0);
        repeat (5) @(negedge clk);
        chk("idle_ack_ovr", 32'(overrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
